// File: rtl/inst_encoder.sv
// RV32I instruction encoder: control-ROM op index plus operands in, 32-bit instruction word out.
// Two-stage valid/ready pipeline. Each word leaves tagged with an auto-incrementing IMEM byte address.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic [15:0] out_count,
  output logic        err_illegal
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // Op numbering matches the control-ROM decoder; each branch has two equivalent indices.
  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BEQ_B, OP_BNE, OP_BNE_B, OP_BLT, OP_BLT_B,
    OP_BGE, OP_BGE_B, OP_BLTU, OP_BLTU_B, OP_BGEU, OP_BGEU_B,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } op_e;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  F7_BASE    = 7'b0000000;
  localparam logic [6:0]  F7_ALT     = 7'b0100000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  function automatic logic [31:0] r_word(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] i_word(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm12);
    return {imm12, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_word(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [11:0] imm12);
    return {imm12[11:5], rs2, rs1, f3, imm12[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] b_word(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] imm13);
    return {imm13[12], imm13[10:5], rs2, rs1, f3, imm13[4:1], imm13[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [20:0] imm);
    logic [31:0] w;
    w = NOP_WORD;
    case (op)
      OP_ADD:   w = r_word(F7_BASE, 3'b000, rd, rs1, rs2);
      OP_SUB:   w = r_word(F7_ALT,  3'b000, rd, rs1, rs2);
      OP_SLL:   w = r_word(F7_BASE, 3'b001, rd, rs1, rs2);
      OP_SLT:   w = r_word(F7_BASE, 3'b010, rd, rs1, rs2);
      OP_SLTU:  w = r_word(F7_BASE, 3'b011, rd, rs1, rs2);
      OP_XOR:   w = r_word(F7_BASE, 3'b100, rd, rs1, rs2);
      OP_SRL:   w = r_word(F7_BASE, 3'b101, rd, rs1, rs2);
      OP_SRA:   w = r_word(F7_ALT,  3'b101, rd, rs1, rs2);
      OP_OR:    w = r_word(F7_BASE, 3'b110, rd, rs1, rs2);
      OP_AND:   w = r_word(F7_BASE, 3'b111, rd, rs1, rs2);
      OP_ADDI:  w = i_word(OPC_OP_IMM, 3'b000, rd, rs1, imm[11:0]);
      OP_SLTI:  w = i_word(OPC_OP_IMM, 3'b010, rd, rs1, imm[11:0]);
      OP_SLTIU: w = i_word(OPC_OP_IMM, 3'b011, rd, rs1, imm[11:0]);
      OP_XORI:  w = i_word(OPC_OP_IMM, 3'b100, rd, rs1, imm[11:0]);
      OP_ORI:   w = i_word(OPC_OP_IMM, 3'b110, rd, rs1, imm[11:0]);
      OP_ANDI:  w = i_word(OPC_OP_IMM, 3'b111, rd, rs1, imm[11:0]);
      OP_SLLI:  w = i_word(OPC_OP_IMM, 3'b001, rd, rs1, {F7_BASE, imm[4:0]});
      OP_SRLI:  w = i_word(OPC_OP_IMM, 3'b101, rd, rs1, {F7_BASE, imm[4:0]});
      OP_SRAI:  w = i_word(OPC_OP_IMM, 3'b101, rd, rs1, {F7_ALT, imm[4:0]});
      OP_LB:    w = i_word(OPC_LOAD, 3'b000, rd, rs1, imm[11:0]);
      OP_LH:    w = i_word(OPC_LOAD, 3'b001, rd, rs1, imm[11:0]);
      OP_LW:    w = i_word(OPC_LOAD, 3'b010, rd, rs1, imm[11:0]);
      OP_LBU:   w = i_word(OPC_LOAD, 3'b100, rd, rs1, imm[11:0]);
      OP_LHU:   w = i_word(OPC_LOAD, 3'b101, rd, rs1, imm[11:0]);
      OP_SB:    w = s_word(3'b000, rs1, rs2, imm[11:0]);
      OP_SH:    w = s_word(3'b001, rs1, rs2, imm[11:0]);
      OP_SW:    w = s_word(3'b010, rs1, rs2, imm[11:0]);
      OP_BEQ,  OP_BEQ_B:  w = b_word(3'b000, rs1, rs2, imm[12:0]);
      OP_BNE,  OP_BNE_B:  w = b_word(3'b001, rs1, rs2, imm[12:0]);
      OP_BLT,  OP_BLT_B:  w = b_word(3'b100, rs1, rs2, imm[12:0]);
      OP_BGE,  OP_BGE_B:  w = b_word(3'b101, rs1, rs2, imm[12:0]);
      OP_BLTU, OP_BLTU_B: w = b_word(3'b110, rs1, rs2, imm[12:0]);
      OP_BGEU, OP_BGEU_B: w = b_word(3'b111, rs1, rs2, imm[12:0]);
      OP_LUI:   w = {imm[19:0], rd, OPC_LUI};
      OP_AUIPC: w = {imm[19:0], rd, OPC_AUIPC};
      OP_JAL:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      OP_JALR:  w = i_word(OPC_JALR, 3'b000, rd, rs1, imm[11:0]);
      default:  w = NOP_WORD;
    endcase
    return w;
  endfunction

  // Stage-1 payload
  logic        s1_v;
  logic [5:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [20:0] s1_imm;

  logic             s2_v;
  logic [IDX_W-1:0] word_idx;
  logic             s1_adv;
  logic             in_accept;
  logic             out_hs;
  logic             s1_illegal;
  logic [31:0]      enc_word;

  // Immediate bits above [20] never reach any instruction format.
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:21];

  assign s1_adv     = s1_v & (~s2_v | out_ready);
  assign in_ready   = ~s1_v | s1_adv;
  assign in_accept  = in_valid & in_ready;
  assign out_hs     = s2_v & out_ready;
  assign out_valid  = s2_v;
  assign s1_illegal = (s1_op > 6'(OP_JALR));

  // NOTE: default assignment first so every path drives enc_word and no latch is inferred.
  always_comb begin
    enc_word = NOP_WORD;
    enc_word = encode(s1_op, s1_rd, s1_rs1, s1_rs2, s1_imm);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
    end else if (clr) begin
      s1_v <= 1'b0;
    end else if (in_accept) begin
      s1_v <= 1'b1;
    end else if (s1_adv) begin
      s1_v <= 1'b0;
    end
  end

  // NOTE: the payload has no reset because s1_v qualifies it, so its reset value is never observed.
  always_ff @(posedge clk) begin
    if (in_accept) begin
      s1_op  <= in_op;
      s1_rd  <= in_rd;
      s1_rs1 <= in_rs1;
      s1_rs2 <= in_rs2;
      s1_imm <= in_imm[20:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      out_inst <= '0;
    end else if (clr) begin
      s2_v     <= 1'b0;
      out_inst <= '0;
    end else if (s1_adv) begin
      s2_v     <= 1'b1;
      out_inst <= enc_word;
    end else if (out_hs) begin
      s2_v     <= 1'b0;
    end
  end

  // The address and count follow output handshakes. clr wins over a handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr  <= BASE_ADDR;
      word_idx  <= '0;
      out_count <= '0;
    end else if (clr) begin
      out_addr  <= BASE_ADDR;
      word_idx  <= '0;
      out_count <= '0;
    end else if (out_hs) begin
      if (word_idx == IDX_W'(DEPTH_WORDS - 1)) begin
        out_addr <= BASE_ADDR;
        word_idx <= '0;
      end else begin
        out_addr <= out_addr + 32'd4;
        word_idx <= word_idx + 1'b1;
      end
      if (out_count != 16'hFFFF) out_count <= out_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else if (clr) begin
      err_illegal <= 1'b0;
    end else if (s1_adv && s1_illegal) begin
      err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, latency, backpressure, address wrap, illegal ops, clr and reset.
// A second instance with DEPTH_WORDS=4 shares the stimulus and is used to check address wrap.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_ready;

  logic        in_ready, out_valid, err_illegal;
  logic [31:0] out_inst, out_addr;
  logic [15:0] out_count;
  logic        in_ready4, out_valid4, err_illegal4;
  logic [31:0] out_inst4, out_addr4;
  logic [15:0] out_count4;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .out_count(out_count), .err_illegal(err_illegal)
  );

  inst_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(out_ready), .out_inst(out_inst4), .out_addr(out_addr4),
    .out_count(out_count4), .err_illegal(err_illegal4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_op  = op;
    in_rd  = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
  endtask

  // One word through an empty pipeline with out_ready high: two-cycle latency, then one handshake.
  task automatic issue(input string tag, input logic [5:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [31:0] exp);
    drive(op, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, out_inst, exp);
    check({tag, "_addr"}, out_addr, exp_addr);
    step();
    exp_addr = exp_addr + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stream_words [5];
    int          sent;
    int          got;
    logic        acc;
    logic        hs;
    logic        stalled;
    logic [31:0] held_inst;

    stream_words = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093, 32'h00500093};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #12;
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_out_inst",  out_inst,         32'd0);
    check("rst_out_addr",  out_addr,         32'd0);
    check("rst_out_count", 32'(out_count),   32'd0);
    check("rst_err",       32'(err_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single-word encodings
    exp_addr = 32'd0;
    issue("add",    6'd0,  5'd3,  5'd1, 5'd2, 32'd0,          32'h002081B3);
    issue("srai",   6'd18, 5'd5,  5'd6, 5'd0, 32'd3,          32'h40335293);
    issue("sw",     6'd26, 5'd0,  5'd2, 5'd7, 32'd8,          32'h00712423);
    issue("beq27",  6'd27, 5'd0,  5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE208EE3);
    issue("beq28",  6'd28, 5'd0,  5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE208EE3);
    issue("jal",    6'd41, 5'd1,  5'd0, 5'd0, 32'd2048,       32'h001000EF);
    issue("lui",    6'd39, 5'd10, 5'd0, 5'd0, 32'h0001_2345,  32'h12345537);
    issue("jalr",   6'd42, 5'd1,  5'd5, 5'd0, 32'd16,         32'h010280E7);
    issue("lw",     6'd21, 5'd4,  5'd3, 5'd0, 32'hFFFF_FFF8,  32'hFF81A203);
    issue("bne30",  6'd30, 5'd0,  5'd1, 5'd2, 32'd8,          32'h00209463);
    issue("auipc",  6'd40, 5'd2,  5'd0, 5'd0, 32'hABCF_FFFF,  32'hFFFFF117);
    check("count11",  32'(out_count),  32'd11);
    check("count11_d4", 32'(out_count4), 32'd11);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_addr",  out_addr,        32'd0);
    check("clr_count", 32'(out_count),  32'd0);

    // Five-word stream with out_ready low in cycles 2..4
    sent = 0; got = 0; stalled = 1'b0; held_inst = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (sent < 5);
      drive(6'd10, 5'd1, 5'd0, 5'd0, 32'(sent + 1));
      #1;
      if (stalled) check("stream_stable", out_inst, held_inst);
      acc = in_valid & in_ready;
      hs  = out_valid & out_ready;
      stalled   = out_valid & ~out_ready;
      held_inst = out_inst;
      if (hs) begin
        check("stream_inst",   out_inst,  stream_words[got]);
        check("stream_addr",   out_addr,  32'(got * 4));
        check("stream_addr4",  out_addr4, 32'((got % 4) * 4));
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (hs) got++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent",   32'(sent),       32'd5);
    check("stream_got",    32'(got),        32'd5);
    check("stream_count",  32'(out_count),  32'd5);
    check("stream_count4", 32'(out_count4), 32'd5);
    check("stream_addr_next", out_addr,    32'd20);
    check("stream_addr4_next", out_addr4,  32'd4);
    check("stream_empty",  32'(out_valid),  32'd0);

    // Illegal op: NOP emitted, sticky error until clr
    exp_addr = 32'd20;
    issue("illegal", 6'd50, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF, 32'h00000013);
    check("err_set",   32'(err_illegal),  32'd1);
    check("err_set4",  32'(err_illegal4), 32'd1);
    issue("sub_after", 6'd1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3);
    check("err_sticky", 32'(err_illegal), 32'd1);

    // Hold a word, then clr together with out_ready: beat dropped, everything cleared
    drive(6'd9, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_inst",  out_inst,       32'h0020F1B3);
    clr = 1'b1;
    out_ready = 1'b1;
    step();
    clr = 1'b0;
    check("clr2_valid", 32'(out_valid),   32'd0);
    check("clr2_count", 32'(out_count),   32'd0);
    check("clr2_addr",  out_addr,         32'd0);
    check("clr2_err",   32'(err_illegal), 32'd0);

    // Async reset mid-stream with both stages full
    exp_addr = 32'd0;
    issue("xor", 6'd5, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020C1B3);
    drive(6'd8, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    check("bp_valid",    32'(out_valid), 32'd1);
    check("bp_in_ready", 32'(in_ready),  32'd0);
    check("bp_count",    32'(out_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid",    32'(out_valid), 32'd0);
    check("arst_addr",     out_addr,       32'd0);
    check("arst_count",    32'(out_count), 32'd0);
    check("arst_in_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    check("arst_flushed", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
